// File: rtl/psram_arb_pkg.sv
// psram_pkg: shared types, counter widths and packed-bus helpers for the PSRAM arbiter.
package psram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RECOV} st_t;
  // Sized for the largest supported timeout so one width serves every TMO.
  localparam int TMOW = $clog2(255 + 1);
  localparam int TURNW = 4;
  function automatic int slc(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/psram_arb_if.sv
// psram_arb_if: system-side requester bus shared by all masters of the PSRAM arbiter.
interface psram_arb_if #(parameter int NREQ = 4, parameter int DATAW = 16, parameter int ADRW = 18);
  logic [NREQ-1:0] req_stb_i;
  logic [NREQ-1:0] req_we_i;
  logic [NREQ*ADRW-1:0] req_adr_i;
  logic [NREQ*DATAW-1:0] req_dat_i;
  logic [NREQ-1:0] req_ack_o;
  logic [NREQ-1:0] req_err_o;
  logic [DATAW-1:0] req_dat_o;
  modport master (output req_stb_i, req_we_i, req_adr_i, req_dat_i, input req_ack_o, req_err_o, req_dat_o);
  modport slave (input req_stb_i, req_we_i, req_adr_i, req_dat_i, output req_ack_o, req_err_o, req_dat_o);
endinterface

// File: rtl/psram_arb_rr_pick.sv
// psram_rr_pick: combinational round-robin pick starting one past the pointer.
module psram_rr_pick #(parameter int N = 4) (
  input  logic [N-1:0] el_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic vld_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  // Scan from the farthest slot down so the nearest eligible one overrides.
  always_comb begin
    vld_o = |el_i;
    idx_o = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (el_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/psram_arb.sv
// psram_arb: round-robin sharing of one PSRAM timing core, with ack timeout and recovery reset.
module psram_arb
  import psram_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATAW = 16,
  parameter int ADRW = 18,
  parameter int TURN = 1,
  parameter int TMO = 64,
  localparam int GW = $clog2(NREQ)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  psram_arb_if.slave bus,
  output logic tc_stb_o,
  output logic tc_we_o,
  input  logic tc_ack_i,
  output logic tc_rst_o,
  output logic [ADRW-1:0] mem_adr_o,
  output logic [DATAW-1:0] mem_dat_o,
  output logic mem_dat_oe_o,
  input  logic [DATAW-1:0] mem_dat_i,
  output logic [GW-1:0] gnt_o,
  output logic busy_o
);
  st_t state_q, state_d;
  logic [GW-1:0] ptr_q, gnt_q, pick;
  logic [TMOW-1:0] cnt_q;
  logic [TURNW-1:0] trn_q;
  logic [NREQ-1:0] ack_q, err_q, elig, sel;
  logic [DATAW-1:0] rdat_q, dat_q;
  logic [ADRW-1:0] adr_q;
  logic stb_q, we_q, oe_q, trst_q, pv, grant, ack_go, tmo_go, done;
  // Masking the pulsing requester avoids regranting it before it can drop stb.
  assign elig = bus.req_stb_i & ~ack_q & ~err_q;
  assign sel = NREQ'(1) << gnt_q;
  psram_rr_pick #(.N(NREQ)) u_pick (.el_i(elig), .ptr_i(ptr_q), .vld_o(pv), .idx_o(pick));
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = grant ? WAIT : done ? (TURN == 0 ? IDLE : RECOV) :
              (state_q == RECOV && trn_q == '0) ? IDLE : state_q;
  end
  always_comb begin
    busy_o = state_q != IDLE;
    grant = state_q == IDLE && pv;
    ack_go = state_q == WAIT && tc_ack_i;
    tmo_go = state_q == WAIT && !tc_ack_i && cnt_q == TMOW'(1);
    done = ack_go || tmo_go;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      ptr_q <= GW'(NREQ - 1);
      gnt_q <= '0;
      cnt_q <= '0;
      trn_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      rdat_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      oe_q <= 1'b0;
      trst_q <= 1'b1;
    end else begin
      stb_q <= grant;
      trst_q <= tmo_go;
      ack_q <= ack_go ? sel : '0;
      err_q <= tmo_go ? sel : '0;
      if (grant) begin
        adr_q <= bus.req_adr_i[slc(int'(pick), ADRW) +: ADRW];
        dat_q <= bus.req_dat_i[slc(int'(pick), DATAW) +: DATAW];
        we_q <= bus.req_we_i[pick];
        oe_q <= bus.req_we_i[pick];
        gnt_q <= pick;
        ptr_q <= pick;
        cnt_q <= TMOW'(TMO);
      end else if (state_q == WAIT) cnt_q <= cnt_q - 1'b1;
      if (done) begin
        oe_q <= 1'b0;
        trn_q <= TURNW'(TURN > 0 ? TURN - 1 : 0);
      end else if (state_q == RECOV) trn_q <= trn_q - 1'b1;
      if (ack_go && !we_q) rdat_q <= mem_dat_i;
    end
  assign tc_stb_o = stb_q;
  assign tc_we_o = we_q;
  assign tc_rst_o = trst_q;
  assign mem_adr_o = adr_q;
  assign mem_dat_o = dat_q;
  assign mem_dat_oe_o = oe_q;
  assign gnt_o = gnt_q;
  assign bus.req_ack_o = ack_q;
  assign bus.req_err_o = err_q;
  assign bus.req_dat_o = rdat_q;
endmodule

// File: tb/tb_psram_arb.sv
// tb_psram_arb: directed scenario tests for psram_arb with hand-computed expectations.
module tb_psram_arb;
  logic clk = 1'b0, rst_n = 1'b0, tc_ack_i = 1'b0;
  logic [15:0] mem_dat_i = '0;
  logic tc_stb, tc_we, tc_rst, oe, busy;
  logic [17:0] mem_adr;
  logic [15:0] mem_dat;
  logic [1:0] gnt;
  int checks = 0, fails = 0;
  psram_arb_if #(.NREQ(4), .DATAW(16), .ADRW(18)) bus();
  psram_arb #(.NREQ(4), .DATAW(16), .ADRW(18), .TURN(1), .TMO(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .tc_stb_o(tc_stb), .tc_we_o(tc_we),
    .tc_ack_i(tc_ack_i), .tc_rst_o(tc_rst), .mem_adr_o(mem_adr), .mem_dat_o(mem_dat),
    .mem_dat_oe_o(oe), .mem_dat_i(mem_dat_i), .gnt_o(gnt), .busy_o(busy));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, tc_stb, tc_we, oe, tc_rst} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=00001", {busy, tc_stb, tc_we, oe, tc_rst});
    end
    checks++;
    if ({mem_adr, mem_dat, gnt, bus.req_dat_o, bus.req_ack_o, bus.req_err_o} !== '0) begin
      fails++;
      $display("FAIL reset_data adr=%h dat=%h gnt=%0d rdat=%h ack=%b err=%b", mem_adr, mem_dat, gnt, bus.req_dat_o, bus.req_ack_o, bus.req_err_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({tc_rst, busy} !== 2'b00) begin
      fails++;
      $display("FAIL reset_release got=%b exp=00", {tc_rst, busy});
    end
  endtask

  task automatic test_single_read;
    int stbs = 0;
    logic oe_seen = 1'b0;
    bus.req_we_i = 4'b0000;
    bus.req_adr_i[0 +: 18] = 18'h00123;
    bus.req_stb_i = 4'b0001;
    tick();
    checks++;
    if ({tc_stb, tc_we, gnt, mem_adr, busy} !== {1'b1, 1'b0, 2'd0, 18'h00123, 1'b1}) begin
      fails++;
      $display("FAIL read_issue stb=%b we=%b gnt=%0d adr=%h busy=%b", tc_stb, tc_we, gnt, mem_adr, busy);
    end
    if (tc_stb) stbs++;
    if (oe) oe_seen = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (tc_stb) stbs++;
      if (oe) oe_seen = 1'b1;
    end
    tc_ack_i = 1'b1;
    mem_dat_i = 16'hBEEF;
    tick();
    checks++;
    if (stbs !== 1 || oe_seen !== 1'b0) begin
      fails++;
      $display("FAIL read_stb_oe stbs=%0d oe_seen=%b exp 1/0", stbs, oe_seen);
    end
    checks++;
    if ({bus.req_ack_o, bus.req_dat_o, bus.req_err_o} !== {4'b0001, 16'hBEEF, 4'b0000}) begin
      fails++;
      $display("FAIL read_ack ack=%b rdat=%h err=%b exp 0001/beef/0000", bus.req_ack_o, bus.req_dat_o, bus.req_err_o);
    end
    tc_ack_i = 1'b0;
    mem_dat_i = 16'h0000;
    bus.req_stb_i = 4'b0000;
    tick();
    checks++;
    if ({bus.req_ack_o, busy} !== 5'b00000) begin
      fails++;
      $display("FAIL read_done ack=%b busy=%b exp 0000/0", bus.req_ack_o, busy);
    end
  endtask

  task automatic test_single_write;
    bus.req_we_i = 4'b0100;
    bus.req_adr_i[36 +: 18] = 18'h3FFFF;
    bus.req_dat_i[32 +: 16] = 16'h5A5A;
    bus.req_stb_i = 4'b0100;
    tick();
    checks++;
    if ({tc_stb, tc_we, oe, gnt, mem_adr, mem_dat} !== {3'b111, 2'd2, 18'h3FFFF, 16'h5A5A}) begin
      fails++;
      $display("FAIL write_issue stb=%b we=%b oe=%b gnt=%0d adr=%h dat=%h", tc_stb, tc_we, oe, gnt, mem_adr, mem_dat);
    end
    tick();
    checks++;
    if ({tc_stb, oe} !== 2'b01) begin
      fails++;
      $display("FAIL write_hold stb=%b oe=%b exp 0/1", tc_stb, oe);
    end
    tc_ack_i = 1'b1;
    tick();
    checks++;
    if ({bus.req_ack_o, oe, busy, bus.req_dat_o} !== {4'b0100, 1'b0, 1'b1, 16'hBEEF}) begin
      fails++;
      $display("FAIL write_ack ack=%b oe=%b busy=%b rdat=%h", bus.req_ack_o, oe, busy, bus.req_dat_o);
    end
    tc_ack_i = 1'b0;
    bus.req_stb_i = 4'b0000;
    bus.req_we_i = 4'b0000;
    tick();
  endtask

  task automatic test_timeout;
    bus.req_adr_i[18 +: 18] = 18'h01111;
    bus.req_stb_i = 4'b0010;
    tick();
    checks++;
    if ({tc_stb, gnt} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL tmo_issue stb=%b gnt=%0d exp 1/1", tc_stb, gnt);
    end
    for (int k = 1; k <= 63; k++) begin
      tick();
      checks++;
      if ({bus.req_ack_o, bus.req_err_o, tc_rst} !== 9'b0) begin
        fails++;
        $display("FAIL tmo_early cyc=%0d ack=%b err=%b rst=%b", k, bus.req_ack_o, bus.req_err_o, tc_rst);
      end
    end
    tick();
    checks++;
    if ({bus.req_err_o, tc_rst, bus.req_ack_o} !== {4'b0010, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL tmo_err err=%b rst=%b ack=%b exp 0010/1/0000", bus.req_err_o, tc_rst, bus.req_ack_o);
    end
    bus.req_adr_i[54 +: 18] = 18'h00042;
    bus.req_stb_i = 4'b1000;
    tick();
    checks++;
    if ({bus.req_err_o, tc_rst, tc_stb} !== 6'b0) begin
      fails++;
      $display("FAIL tmo_pulse err=%b rst=%b stb=%b exp 0", bus.req_err_o, tc_rst, tc_stb);
    end
    tick();
    checks++;
    if ({tc_stb, gnt, mem_adr} !== {1'b1, 2'd3, 18'h00042}) begin
      fails++;
      $display("FAIL tmo_next stb=%b gnt=%0d adr=%h", tc_stb, gnt, mem_adr);
    end
    tc_ack_i = 1'b1;
    mem_dat_i = 16'h1234;
    tick();
    checks++;
    if ({bus.req_ack_o, bus.req_dat_o} !== {4'b1000, 16'h1234}) begin
      fails++;
      $display("FAIL tmo_next_ack ack=%b rdat=%h exp 1000/1234", bus.req_ack_o, bus.req_dat_o);
    end
    tc_ack_i = 1'b0;
    bus.req_stb_i = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_collision;
    bus.req_adr_i[0 +: 18] = 18'h00777;
    bus.req_stb_i = 4'b0001;
    tick();
    checks++;
    if ({tc_stb, gnt} !== {1'b1, 2'd0}) begin
      fails++;
      $display("FAIL col_issue stb=%b gnt=%0d exp 1/0", tc_stb, gnt);
    end
    for (int k = 1; k <= 63; k++) tick();
    tc_ack_i = 1'b1;
    mem_dat_i = 16'hCAFE;
    tick();
    checks++;
    if ({bus.req_ack_o, bus.req_err_o, tc_rst, bus.req_dat_o} !== {4'b0001, 4'b0000, 1'b0, 16'hCAFE}) begin
      fails++;
      $display("FAIL col_ack ack=%b err=%b rst=%b rdat=%h", bus.req_ack_o, bus.req_err_o, tc_rst, bus.req_dat_o);
    end
    tc_ack_i = 1'b0;
    bus.req_stb_i = 4'b0000;
    tick();
    checks++;
    if ({bus.req_err_o, tc_rst} !== 5'b0) begin
      fails++;
      $display("FAIL col_after err=%b rst=%b exp 0", bus.req_err_o, tc_rst);
    end
    tick();
  endtask

  task automatic test_fairness;
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int n = 0, idx;
    logic [3:0] drop = '0;
    logic pend = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.req_we_i = 4'b0000;
    mem_dat_i = 16'h7777;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      bus.req_stb_i = ~drop;
      drop = bus.req_ack_o;
      tc_ack_i = pend;
      pend = tc_stb;
      if (|bus.req_ack_o) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (bus.req_ack_o[i]) idx = i;
        checks++;
        if (!$onehot(bus.req_ack_o) || idx != exp_o[n]) begin
          fails++;
          $display("FAIL rr_order n=%0d ack=%b exp_idx=%0d", n, bus.req_ack_o, exp_o[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      fails++;
      $display("FAIL rr_timeout acks=%0d exp 5", n);
    end
    bus.req_stb_i = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      tc_ack_i = pend;
      pend = tc_stb;
    end
    tc_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    bus.req_we_i = 4'b0100;
    bus.req_adr_i[36 +: 18] = 18'h2AAAA;
    bus.req_dat_i[32 +: 16] = 16'h1111;
    bus.req_stb_i = 4'b0100;
    tick();
    tick();
    checks++;
    if ({busy, oe, mem_adr} !== {2'b11, 18'h2AAAA}) begin
      fails++;
      $display("FAIL arst_pre busy=%b oe=%b adr=%h", busy, oe, mem_adr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, oe, tc_stb, tc_we, tc_rst} !== 5'b00001) begin
      fails++;
      $display("FAIL arst_ctrl got=%b exp=00001", {busy, oe, tc_stb, tc_we, tc_rst});
    end
    checks++;
    if ({mem_adr, mem_dat, gnt, bus.req_dat_o} !== '0) begin
      fails++;
      $display("FAIL arst_data adr=%h dat=%h gnt=%0d rdat=%h exp 0", mem_adr, mem_dat, gnt, bus.req_dat_o);
    end
    tick();
    rst_n = 1'b1;
    bus.req_stb_i = 4'b0000;
    tc_ack_i = 1'b1;
    tick();
    tc_ack_i = 1'b0;
    checks++;
    if (tc_rst !== 1'b0) begin
      fails++;
      $display("FAIL arst_release rst=%b exp 0", tc_rst);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({bus.req_ack_o, bus.req_err_o, busy} !== 9'b0) begin
        fails++;
        $display("FAIL arst_quiet cyc=%0d ack=%b err=%b busy=%b", k, bus.req_ack_o, bus.req_err_o, busy);
      end
    end
  endtask

  initial begin
    bus.req_stb_i = '0;
    bus.req_we_i = '0;
    bus.req_adr_i = '0;
    bus.req_dat_i = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_timeout();
    test_collision();
    test_fairness();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
